// File: rtl/xs3_bcd_subtractor_if.sv
// Operand/result handshake bundle for the excess-3 BCD subtractor.
// The master drives operands and out_ready; the slave (the subtractor) returns the result.
interface xs3_bcd_subtractor_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DIGITS-1:0]   a_xs3;
    logic [4*DIGITS-1:0]   b_xs3;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   diff;
    logic                  neg;
    logic                  err;

    modport master (
        output in_valid, a_xs3, b_xs3, out_ready,
        input  in_ready, out_valid, diff, neg, err
    );

    modport slave (
        input  in_valid, a_xs3, b_xs3, out_ready,
        output in_ready, out_valid, diff, neg, err
    );
endinterface

// File: rtl/xs3_bcd_subtractor.sv
// Digit-serial |A-B| for excess-3 operands, LSD first, packed BCD result plus sign flag.
// Define XS3_OUT_EN to re-encode the result nibbles to excess-3 when the result is loaded.
module xs3_bcd_subtractor #(
    parameter int unsigned DIGITS = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    xs3_bcd_subtractor_if.slave bus
);
    localparam int unsigned W    = 4 * DIGITS;
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef XS3_OUT_EN
    localparam logic [W-1:0] ErrDiff = {DIGITS{4'h3}};
`else
    localparam logic [W-1:0] ErrDiff = '0;
`endif

    function automatic logic [W-1:0] out_enc(input logic [W-1:0] v);
`ifdef XS3_OUT_EN
        logic [W-1:0] r;
        for (int j = 0; j < int'(DIGITS); j++) r[j*4 +: 4] = v[j*4 +: 4] + 4'd3;
        return r;
`else
        return v;
`endif
    endfunction

    // StCheck gives the operand legality check its own cycle after the accept edge.
    typedef enum logic [2:0] {StIdle, StCheck, StSub, StComp, StDone} state_e;

    state_e            state_q;
    logic              in_ready_q, out_valid_q, neg_q, err_q, borrow_q;
    logic [W-1:0]      a_q, b_q, res_q, diff_q;
    logic [IdxW-1:0]   idx_q;

    logic              illegal, last, bout;
    logic [3:0]        a_nib, b_nib, r_nib, dig;
    logic signed [4:0] da, db, lhs, rhs, t, tc;
    logic [W-1:0]      res_wr;

    always_comb begin
        illegal = 1'b0;
        for (int j = 0; j < int'(DIGITS); j++) begin
            if (a_q[j*4 +: 4] < 4'd3 || a_q[j*4 +: 4] > 4'd12 ||
                b_q[j*4 +: 4] < 4'd3 || b_q[j*4 +: 4] > 4'd12) begin
                illegal = 1'b1;
            end
        end
    end

    // One shared 5-bit signed digit subtractor serves both SUB and the 10's complement pass.
    always_comb begin
        a_nib = a_q[idx_q*4 +: 4];
        b_nib = b_q[idx_q*4 +: 4];
        r_nib = res_q[idx_q*4 +: 4];
        da    = $signed({1'b0, a_nib}) - 5'sd3;
        db    = $signed({1'b0, b_nib}) - 5'sd3;
        if (state_q == StComp) begin
            lhs = '0;
            rhs = $signed({1'b0, r_nib});
        end else begin
            lhs = da;
            rhs = db;
        end
        t      = lhs - rhs - $signed({4'b0, borrow_q});
        tc     = t + 5'sd10;
        bout   = t[4];
        dig    = bout ? tc[3:0] : t[3:0];
        res_wr = res_q;
        res_wr[idx_q*4 +: 4] = dig;
        last   = (idx_q == IdxW'(DIGITS - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            diff_q      <= '0;
            neg_q       <= 1'b0;
            err_q       <= 1'b0;
            borrow_q    <= 1'b0;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a_xs3;
                        b_q        <= bus.b_xs3;
                        res_q      <= '0;
                        borrow_q   <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= StCheck;
                    end
                end
                StCheck: begin
                    if (illegal) begin
                        diff_q      <= ErrDiff;
                        neg_q       <= 1'b0;
                        err_q       <= 1'b1;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        state_q <= StSub;
                    end
                end
                StSub: begin
                    res_q    <= res_wr;
                    borrow_q <= bout;
                    idx_q    <= idx_q + 1'b1;
                    if (last) begin
                        idx_q <= '0;
                        if (!bout) begin
                            diff_q      <= out_enc(res_wr);
                            neg_q       <= 1'b0;
                            err_q       <= 1'b0;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            borrow_q <= 1'b0;
                            state_q  <= StComp;
                        end
                    end
                end
                StComp: begin
                    res_q    <= res_wr;
                    borrow_q <= bout;
                    idx_q    <= idx_q + 1'b1;
                    if (last) begin
                        idx_q       <= '0;
                        diff_q      <= out_enc(res_wr);
                        neg_q       <= 1'b1;
                        err_q       <= 1'b0;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.diff      = diff_q;
    assign bus.neg       = neg_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_xs3_bcd_subtractor.sv
// Self-checking bench for xs3_bcd_subtractor: directed table, random vs. integer model, corners.
module tb_xs3_bcd_subtractor;
    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    xs3_bcd_subtractor_if #(.DIGITS(DIGITS)) bus ();

    xs3_bcd_subtractor #(.DIGITS(DIGITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] d;
        logic         n;
        logic         e;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] enc(input logic [W-1:0] d);
`ifdef XS3_OUT_EN
        logic [W-1:0] r;
        for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = d[i*4 +: 4] + 4'd3;
        return r;
`else
        return d;
`endif
    endfunction

    // Reference: decode to integers, take |A-B|, re-encode as decimal digits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W-1:0] d,
                         output logic n, output logic e, output int lat);
        int av = 0, bv = 0, scale = 1, mag;
        e = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            int an = int'(a[i*4 +: 4]);
            int bn = int'(b[i*4 +: 4]);
            if (an < 3 || an > 12 || bn < 3 || bn > 12) e = 1'b1;
            av += (an - 3) * scale;
            bv += (bn - 3) * scale;
            scale *= 10;
        end
        d = '0;
        n = 1'b0;
        if (e) begin
            lat = 1;
        end else begin
            n   = (av < bv);
            mag = n ? bv - av : av - bv;
            lat = n ? 2 * DIGITS + 1 : DIGITS + 1;
            for (int i = 0; i < DIGITS; i++) begin
                d[i*4 +: 4] = 4'(mag % 10);
                mag /= 10;
            end
        end
        d = enc(d);
    endtask

    // Issue one operand pair and wait for out_valid; returns edges from accept to valid.
    task automatic start_and_wait(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        int guard = 0;
        while (!bus.in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.in_valid = 1'b1;
        bus.a_xs3    = a;
        bus.b_xs3    = b;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, output logic [W-1:0] d,
                         output logic n, output logic e, output int lat);
        start_and_wait(a, b, lat);
        d = bus.diff;
        n = bus.neg;
        e = bus.err;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [W-1:0] a, b, d, ed, d0;
        logic         n, e, en, ee;
        int           lat, elat, seen, pos;

        vecs[0] = '{16'h3854, 16'h346A, 16'h0384, 1'b0, 1'b0, 5};
        vecs[1] = '{16'h346A, 16'h3854, 16'h0384, 1'b1, 1'b0, 9};
        vecs[2] = '{16'hCCCC, 16'h3333, 16'h9999, 1'b0, 1'b0, 5};
        vecs[3] = '{16'h3333, 16'h3334, 16'h0001, 1'b1, 1'b0, 9};
        vecs[4] = '{16'h3856, 16'h3856, 16'h0000, 1'b0, 1'b0, 5};
        vecs[5] = '{16'h3851, 16'h3333, 16'h0000, 1'b0, 1'b1, 1};
        vecs[6] = '{16'h3333, 16'hD333, 16'h0000, 1'b0, 1'b1, 1};
        vecs[7] = '{16'h3333, 16'hCCCC, 16'h9999, 1'b1, 1'b0, 9};

        bus.in_valid  = 1'b0;
        bus.a_xs3     = '0;
        bus.b_xs3     = '0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);
        check("rst_diff", 32'(bus.diff), 0);
        check("rst_neg", 32'(bus.neg), 0);
        check("rst_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, d, n, e, lat);
            check($sformatf("vec%0d_diff", i), 32'(d), 32'(enc(vecs[i].d)));
            check($sformatf("vec%0d_neg", i), 32'(n), 32'(vecs[i].n));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
        end

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                a[i*4 +: 4] = 4'($urandom_range(3, 12));
                b[i*4 +: 4] = 4'($urandom_range(3, 12));
            end
            if ($urandom_range(0, 7) == 0) begin
                pos = int'($urandom_range(0, DIGITS - 1));
                a[pos*4 +: 4] = 4'($urandom_range(0, 15));
            end
            model(a, b, ed, en, ee, elat);
            do_op(a, b, d, n, e, lat);
            check($sformatf("rnd%0d_diff", k), 32'(d), 32'(ed));
            check($sformatf("rnd%0d_neg", k), 32'(n), 32'(en));
            check($sformatf("rnd%0d_err", k), 32'(e), 32'(ee));
            check($sformatf("rnd%0d_lat", k), lat, elat);
        end

        // Backpressure: result must hold and new operands must be refused.
        bus.out_ready = 1'b0;
        start_and_wait(16'h346A, 16'h3854, lat);
        check("bp_lat", lat, 9);
        d0 = bus.diff;
        check("bp_diff0", 32'(d0), 32'(enc(16'h0384)));
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = c[0];
            bus.a_xs3    = 16'h3333;
            bus.b_xs3    = 16'h3333;
            @(posedge clk); #1;
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_diff", 32'(bus.diff), 32'(d0));
            check("bp_neg", 32'(bus.neg), 1);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(bus.out_valid), 0);
        check("bp_release_ready", 32'(bus.in_ready), 1);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("bp_no_extra_result", seen, 0);

        // Reset two cycles into SUB of a negative operation (outputs hold the previous result).
        bus.in_valid = 1'b1;
        bus.a_xs3    = 16'h346A;
        bus.b_xs3    = 16'h3854;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_diff", 32'(bus.diff), 0);
        check("mid_rst_neg", 32'(bus.neg), 0);
        check("mid_rst_err", 32'(bus.err), 0);
        check("mid_rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen++;
        end
        check("post_rst_no_output", seen, 0);
        do_op(16'h3854, 16'h346A, d, n, e, lat);
        check("post_rst_diff", 32'(d), 32'(enc(16'h0384)));
        check("post_rst_neg", 32'(n), 0);
        check("post_rst_lat", lat, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
